// File: rtl/mrd_pkg.sv
// Shared constants and types for the mixed-radix write-back stage.
package mrd_pkg;

  localparam int unsigned N_LANE      = 5;
  localparam int unsigned W_DATA      = 30;
  localparam int unsigned W_BANK_ADDR = 8;
  localparam int unsigned W_BANK_IDX  = 3;

  typedef struct packed {
    logic signed [W_DATA-1:0] re;
    logic signed [W_DATA-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} wr_state_t;

endpackage

// File: rtl/mrd_bank_ram.sv
// One RAM bank: single write port, N_LANE read ports, read-first, 1-cycle read latency.
module mrd_bank_ram
  import mrd_pkg::*;
(
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [W_BANK_ADDR-1:0]        i_waddr,
  input  cplx_t                         i_wdata,
  input  logic [N_LANE*W_BANK_ADDR-1:0] i_raddr,
  output cplx_t [N_LANE-1:0]            o_rdata
);

  localparam int unsigned DEPTH = 1 << W_BANK_ADDR;

  cplx_t             r_mem [DEPTH];
  cplx_t [N_LANE-1:0] r_rdata;

  // Non-blocking read and write on the same edge gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    for (int k = 0; k < N_LANE; k++) begin
      r_rdata[k] <= r_mem[i_raddr[k*W_BANK_ADDR +: W_BANK_ADDR]];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mrd_stage_mem_wr.sv
// Write-back stage: registers DFT output beats, routes lanes through a 5x5 crossbar into
// five RAM banks, counts beats against the stage length and exposes a 5-lane read port.
module mrd_stage_mem_wr
  import mrd_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_stage_start,
  input  logic [W_BANK_ADDR:0]          i_stage_beats,
  input  logic [2:0]                    i_factor,
  input  logic                          i_in_valid,
  input  logic [N_LANE*W_DATA-1:0]      i_in_real,
  input  logic [N_LANE*W_DATA-1:0]      i_in_imag,
  input  logic [N_LANE*W_BANK_IDX-1:0]  i_in_bank_index,
  input  logic [N_LANE*W_BANK_ADDR-1:0] i_in_bank_addr,
  input  logic [N_LANE*W_BANK_IDX-1:0]  i_rd_bank_index,
  input  logic [N_LANE*W_BANK_ADDR-1:0] i_rd_addr,
  output logic [N_LANE*W_DATA-1:0]      o_rd_real,
  output logic [N_LANE*W_DATA-1:0]      o_rd_imag,
  output logic                          o_busy,
  output logic                          o_wr_done,
  output logic [2:0]                    o_err_flags
);

  wr_state_t              r_state, w_state_nxt;
  logic [W_BANK_ADDR:0]   r_count, w_count_nxt, r_target;
  logic [2:0]             r_factor;
  logic                   w_start;
  logic [2:0]             r_err, w_err_new;
  logic                   r_wr_done;

  logic [W_BANK_IDX-1:0]  w_lane_bank [N_LANE];
  logic [N_LANE-1:0]      w_lane_en, w_lane_we, w_lane_range;
  logic                   w_collide;

  logic [N_LANE-1:0]      r_s1_we;
  logic [W_BANK_IDX-1:0]  r_s1_bank [N_LANE];
  logic [W_BANK_ADDR-1:0] r_s1_addr [N_LANE];
  cplx_t                  r_s1_data [N_LANE];

  logic [N_LANE-1:0]      w_bank_we;
  logic [W_BANK_ADDR-1:0] w_bank_addr [N_LANE];
  cplx_t                  w_bank_wdata [N_LANE];
  cplx_t [N_LANE-1:0]     w_bank_rd [N_LANE];
  logic [W_BANK_IDX-1:0]  r_rd_sel [N_LANE];

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_start     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_stage_start) begin
          w_state_nxt = RUN;
          w_count_nxt = '0;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        if (i_in_valid) begin
          w_count_nxt = r_count + 1'b1;
          if (w_count_nxt == r_target) begin
            w_state_nxt = FLUSH;
          end
        end
      end
      FLUSH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Lower lane index wins a contested bank; out-of-range banks drop the lane only.
  always_comb begin
    w_lane_en    = '0;
    w_lane_we    = '0;
    w_lane_range = '0;
    w_collide    = 1'b0;
    for (int k = 0; k < N_LANE; k++) begin
      w_lane_bank[k]  = i_in_bank_index[k*W_BANK_IDX +: W_BANK_IDX];
      w_lane_range[k] = i_in_valid && (r_state == RUN) && (3'(k) < r_factor) &&
                        (w_lane_bank[k] > 3'(N_LANE-1));
      w_lane_en[k]    = i_in_valid && (r_state == RUN) && (3'(k) < r_factor) &&
                        (w_lane_bank[k] <= 3'(N_LANE-1));
    end
    for (int k = 0; k < N_LANE; k++) begin
      w_lane_we[k] = w_lane_en[k];
      for (int j = 0; j < k; j++) begin
        if (w_lane_en[j] && w_lane_en[k] && (w_lane_bank[j] == w_lane_bank[k])) begin
          w_lane_we[k] = 1'b0;
          w_collide    = 1'b1;
        end
      end
    end
    w_err_new = {i_in_valid && (r_state != RUN), |w_lane_range, w_collide};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_target  <= '0;
      r_factor  <= '0;
      r_err     <= '0;
      r_wr_done <= 1'b0;
      r_s1_we   <= '0;
      for (int k = 0; k < N_LANE; k++) begin
        r_rd_sel[k] <= '1;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      if (w_start) begin
        r_target <= (i_stage_beats == '0) ? {1'b1, {W_BANK_ADDR{1'b0}}} : i_stage_beats;
        r_factor <= i_factor;
      end
      r_err     <= (w_start ? 3'b000 : r_err) | w_err_new;
      r_wr_done <= (r_state == FLUSH);
      r_s1_we   <= w_lane_we;
      for (int k = 0; k < N_LANE; k++) begin
        r_rd_sel[k] <= i_rd_bank_index[k*W_BANK_IDX +: W_BANK_IDX];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_LANE; k++) begin
      r_s1_bank[k]    <= w_lane_bank[k];
      r_s1_addr[k]    <= i_in_bank_addr[k*W_BANK_ADDR +: W_BANK_ADDR];
      r_s1_data[k].re <= i_in_real[k*W_DATA +: W_DATA];
      r_s1_data[k].im <= i_in_imag[k*W_DATA +: W_DATA];
    end
  end

  always_comb begin
    w_bank_we = '0;
    for (int b = 0; b < N_LANE; b++) begin
      w_bank_addr[b]  = '0;
      w_bank_wdata[b] = '0;
      for (int k = 0; k < N_LANE; k++) begin
        if (r_s1_we[k] && (r_s1_bank[k] == 3'(b))) begin
          w_bank_we[b]    = 1'b1;
          w_bank_addr[b]  = r_s1_addr[k];
          w_bank_wdata[b] = r_s1_data[k];
        end
      end
    end
  end

  for (genvar b = 0; b < N_LANE; b++) begin : g_bank
    mrd_bank_ram u_bank (
      .clk     (clk),
      .i_we    (w_bank_we[b]),
      .i_waddr (w_bank_addr[b]),
      .i_wdata (w_bank_wdata[b]),
      .i_raddr (i_rd_addr),
      .o_rdata (w_bank_rd[b])
    );
  end

  always_comb begin
    o_rd_real = '0;
    o_rd_imag = '0;
    for (int k = 0; k < N_LANE; k++) begin
      for (int b = 0; b < N_LANE; b++) begin
        if (r_rd_sel[k] == 3'(b)) begin
          o_rd_real[k*W_DATA +: W_DATA] = w_bank_rd[b][k].re;
          o_rd_imag[k*W_DATA +: W_DATA] = w_bank_rd[b][k].im;
        end
      end
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_wr_done   = r_wr_done;
  assign o_err_flags = r_err;

endmodule
